// File: rtl/decoder_n_buffered.sv
// Join of data token In with select token S, routed into one of NOUT per-output FIFOs.
// Optional broadcast on select code NOUT when DECODER_BCAST_EN is defined.
module decoder_n_buffered #(
    parameter int W     = 9,
    parameter int NOUT  = 2,
    parameter int DEPTH = 2,
    parameter int SW    = $clog2(NOUT + 1)
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic [W-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SW-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [NOUT*W-1:0] out_data,
    output logic [NOUT-1:0]   out_valid,
    input  logic [NOUT-1:0]   out_ready,
    output logic              sel_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [SW-1:0] NOUT_C  = SW'(NOUT);

    logic [W-1:0]    mem_q    [NOUT][DEPTH];
    logic [W-1:0]    mem_d    [NOUT][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NOUT];
    logic [PW-1:0]   wr_ptr_d [NOUT];
    logic [PW-1:0]   rd_ptr_q [NOUT];
    logic [PW-1:0]   rd_ptr_d [NOUT];
    logic [CW-1:0]   count_q  [NOUT];
    logic [CW-1:0]   count_d  [NOUT];
    logic            sel_err_q, sel_err_d;

    logic [NOUT-1:0] pop, space, push, hit;
    logic            legal, bcast, tgt_space, fire;

    // Head is masked while empty so out_data reads zero after reset.
    always_comb begin
        for (int i = 0; i < NOUT; i++) begin
            out_valid[i]        = (count_q[i] != '0);
            out_data[i*W +: W]  = out_valid[i] ? mem_q[i][rd_ptr_q[i]] : '0;
        end
    end

    always_comb begin
        legal = (s_data < NOUT_C);
`ifdef DECODER_BCAST_EN
        bcast = (s_data == NOUT_C);
`else
        bcast = 1'b0;
`endif
        for (int i = 0; i < NOUT; i++) begin
            pop[i]   = out_valid[i] & out_ready[i];
            space[i] = (count_q[i] < DEPTH_C) | pop[i];
            hit[i]   = legal & (s_data == SW'(i));
        end
        // Illegal selects always have "space" so the pair is drained rather than stalling the link.
        if (bcast)      tgt_space = &space;
        else if (legal) tgt_space = |(space & hit);
        else            tgt_space = 1'b1;

        in_ready  = _RESET & s_valid & tgt_space;
        s_ready   = _RESET & in_valid & tgt_space;
        fire      = in_ready & in_valid;
        push      = fire ? (bcast ? {NOUT{1'b1}} : hit) : '0;
        sel_err_d = fire & ~legal & ~bcast;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < NOUT; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i] = (wr_ptr_q[i] == LAST_C) ? '0 : wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == LAST_C) ? '0 : rd_ptr_q[i] + 1'b1;
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + 1'b1;
                2'b01:   count_d[i] = count_q[i] - 1'b1;
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            for (int i = 0; i < NOUT; i++) begin
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
endmodule

// File: tb/tb_decoder_n_buffered.sv
// Scoreboard bench for decoder_n_buffered (W=9, NOUT=2, DEPTH=2); follows DECODER_BCAST_EN.
module tb_decoder_n_buffered;
    logic        CLK = 1'b0;
    logic        _RESET;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        sel_err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    decoder_n_buffered #(.W(9), .NOUT(2), .DEPTH(2)) dut (
        .CLK(CLK), ._RESET(_RESET),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a head is consumed at the next posedge when valid&ready at the negedge.
    always @(negedge CLK) begin
        if (_RESET) begin
            if (out_valid[0] && out_ready[0]) begin
                if (exp_q0.size() == 0) chk("out0_unexpected", {23'd0, out_data[8:0]}, 32'hFFFF_FFFF);
                else chk("out0_data", {23'd0, out_data[8:0]}, {23'd0, exp_q0.pop_front()});
            end
            if (out_valid[1] && out_ready[1]) begin
                if (exp_q1.size() == 0) chk("out1_unexpected", {23'd0, out_data[17:9]}, 32'hFFFF_FFFF);
                else chk("out1_data", {23'd0, out_data[17:9]}, {23'd0, exp_q1.pop_front()});
            end
        end
    end

    task automatic send(input logic [8:0] d, input logic [1:0] s, input int budget,
                        output int waits, output bit ok);
        in_data = d; s_data = s; in_valid = 1'b1; s_valid = 1'b1;
        ok = 1'b0; waits = 0;
        while (!ok && waits < budget) begin
            @(negedge CLK);
            if (in_ready && s_ready) begin
                ok = 1'b1;
                if (s == 2'd0) exp_q0.push_back(d);
                else if (s == 2'd1) exp_q1.push_back(d);
`ifdef DECODER_BCAST_EN
                else if (s == 2'd2) begin exp_q0.push_back(d); exp_q1.push_back(d); end
`endif
            end else begin
                waits++;
            end
            @(posedge CLK); #1;
        end
        if (ok) begin in_valid = 1'b0; s_valid = 1'b0; end
    endtask

    task automatic send_ok(input string name, input logic [8:0] d, input logic [1:0] s);
        int w; bit ok;
        send(d, s, 20, w, ok);
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int w; bit ok;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w; bit ok;
        _RESET = 1'b0; in_valid = 1'b1; s_valid = 1'b1; in_data = 9'h111; s_data = 2'd0;
        out_ready = 2'b11;
        repeat (2) begin
            @(negedge CLK);
            chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
            chk("rst_readies", {30'd0, in_ready, s_ready}, 32'd0);
            chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
            chk("rst_out_data", {14'd0, out_data}, 32'd0);
        end
        @(posedge CLK); #1;
        in_valid = 1'b0; s_valid = 1'b0; _RESET = 1'b1;
        @(posedge CLK); #1;

        // Routing and 1-cycle latency
        send(9'h1A5, 2'd1, 20, w, ok);
        chk("route1_ok", {31'd0, ok}, 32'd1);
        chk("route1_latency", {30'd0, out_valid}, 32'd2);
        send(9'h003, 2'd0, 20, w, ok);
        chk("route0_latency", {31'd0, out_valid[0]}, 32'd1);
        chk("route0_waits", w, 32'd0);
        repeat (3) @(posedge CLK); #1;

        // Isolation: out0 stalled, third token blocks the join
        out_ready = 2'b10;
        send_ok("iso_a", 9'h0A1, 2'd0);
        send_ok("iso_b", 9'h0A2, 2'd0);
        send(9'h0A3, 2'd0, 4, w, ok);
        chk("iso_third_stalls", {31'd0, ok}, 32'd0);
        chk("iso_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("iso_head_held", {23'd0, out_data[8:0]}, 32'h0A1);
        out_ready = 2'b11;
        send_ok("iso_c", 9'h0A3, 2'd0);
        send_ok("iso_out1", 9'h1B0, 2'd1);
        repeat (4) @(posedge CLK); #1;

        // Full FIFO accepts a push in the same cycle it pops
        out_ready = 2'b10;
        send_ok("full_c", 9'h0C1, 2'd0);
        send_ok("full_d", 9'h0C2, 2'd0);
        out_ready = 2'b11;
        send(9'h0C3, 2'd0, 20, w, ok);
        chk("fullpop_ok", {31'd0, ok}, 32'd1);
        chk("fullpop_waits", w, 32'd0);
        out_ready = 2'b10;
        in_data = 9'h0C4; s_data = 2'd0; in_valid = 1'b1; s_valid = 1'b1;
        #1;
        chk("fullpop_count_stays_full", {31'd0, in_ready}, 32'd0);
        chk("fullpop_head", {23'd0, out_data[8:0]}, 32'h0C2);
        in_valid = 1'b0; s_valid = 1'b0;
        out_ready = 2'b11;
        repeat (4) @(posedge CLK); #1;

        // Join skew: data waits for select
        in_data = 9'h055; s_data = 2'd1; in_valid = 1'b1; s_valid = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("skew_in_ready", {31'd0, in_ready}, 32'd0);
            chk("skew_s_ready", {31'd0, s_ready}, 32'd1);
            chk("skew_no_out", {30'd0, out_valid}, 32'd0);
            @(posedge CLK); #1;
        end
        send_ok("skew_accept", 9'h055, 2'd1);
        repeat (3) @(posedge CLK); #1;
        chk("skew_single", {30'd0, out_valid}, 32'd0);

        // Back-to-back throughput
        for (int k = 0; k < 3; k++) begin
            send(9'h160 + 9'(k), 2'd1, 20, w, ok);
            chk("thru_waits", w, 32'd0);
        end
        repeat (3) @(posedge CLK); #1;

        // Select code NOUT
        send(9'h0FF, 2'd2, 20, w, ok);
        chk("s2_ok", {31'd0, ok}, 32'd1);
`ifdef DECODER_BCAST_EN
        chk("s2_bcast_valid", {30'd0, out_valid}, 32'd3);
        chk("s2_bcast_no_err", {31'd0, sel_err}, 32'd0);
`else
        chk("s2_sel_err", {31'd0, sel_err}, 32'd1);
        chk("s2_no_out", {30'd0, out_valid}, 32'd0);
        @(posedge CLK); #1;
        chk("s2_sel_err_end", {31'd0, sel_err}, 32'd0);
`endif
        repeat (3) @(posedge CLK); #1;

        // Select code 3 is always illegal
        send(9'h0EE, 2'd3, 20, w, ok);
        chk("s3_ok", {31'd0, ok}, 32'd1);
        chk("s3_sel_err", {31'd0, sel_err}, 32'd1);
        chk("s3_no_out", {30'd0, out_valid}, 32'd0);
        @(posedge CLK); #1;
        chk("s3_sel_err_end", {31'd0, sel_err}, 32'd0);

        // Mid-operation reset discards buffered tokens
        out_ready = 2'b00;
        send_ok("mr_a", 9'h011, 2'd0);
        _RESET = 1'b0;
        @(posedge CLK); #1;
        _RESET = 1'b1;
        exp_q0.delete();
        chk("midreset_empty", {30'd0, out_valid}, 32'd0);
        out_ready = 2'b11;

        repeat (5) @(posedge CLK); #1;
        chk("drain_q0", exp_q0.size(), 32'd0);
        chk("drain_q1", exp_q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
